// File: rtl/dmem_lsu.sv
// Single-port data memory behind an RV32I load/store front end.
// It handles byte enables, lane replication, load extension, misalignment faults and post-reset clearing.
module dmem_lsu #(
    parameter int  DEPTH          = 4096,
    parameter int  RD_LAT         = 1,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int ADDR_W         = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_INIT  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    logic [0:0]       state;
    logic [IDX_W-1:0] cnt;
    logic [31:0]      mem [DEPTH];

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             fault;
    logic [3:0]       be;
    logic [31:0]      wdat;

    assign busy      = (state == ST_CLEAR);
    assign req_ready = (state == ST_RUN);
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[ADDR_W-1:2];
    assign lane      = req_addr[1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fault = 1'b0;
        be    = 4'b0000;
        wdat  = req_wdata;
        case (req_size)
            2'd0: begin
                be   = 4'b0001 << lane;
                wdat = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                fault = lane[0];
                be    = 4'b0011 << lane;
                wdat  = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                fault = (lane != 2'd0);
                be    = 4'b1111;
            end
            default: fault = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + IDX_W'(1);
            if (cnt == IDX_W'(DEPTH - 1)) begin
                state <= ST_RUN;
                cnt   <= '0;
            end
        end
    end

    logic [31:0] s1_word;

    // NOTE: the array and its read register are deliberately not reset; only the control path is.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
        end else if (accept && req_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= wdat[b*8 +: 8];
            end
        end
        // Read-old-data: a store to this word on the same edge is not visible here.
        if (accept) s1_word <= mem[idx];
    end

    logic       s1_valid;
    logic       s1_fault;
    logic       s1_we;
    logic [1:0] s1_size;
    logic       s1_uns;
    logic [1:0] s1_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_fault <= 1'b0;
            s1_we    <= 1'b0;
            s1_size  <= 2'd0;
            s1_uns   <= 1'b0;
            s1_lane  <= 2'd0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_fault <= fault;
                s1_we    <= req_we;
                s1_size  <= req_size;
                s1_uns   <= req_unsigned;
                s1_lane  <= lane;
            end
        end
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] e_data;
    logic        e_fault;

    assign byte_sel = s1_word[{s1_lane, 3'b000} +: 8];
    assign half_sel = s1_lane[1] ? s1_word[31:16] : s1_word[15:0];
    assign e_fault  = s1_valid && s1_fault;

    // Stores and faults return zero data.
    always_comb begin
        e_data = '0;
        if (s1_valid && !s1_fault && !s1_we) begin
            case (s1_size)
                2'd0:    e_data = {{24{byte_sel[7] & ~s1_uns}}, byte_sel};
                2'd1:    e_data = {{16{half_sel[15] & ~s1_uns}}, half_sel};
                default: e_data = s1_word;
            endcase
        end
    end

    generate
        if (RD_LAT <= 1) begin : g_lat1
            assign rsp_valid = s1_valid;
            assign rsp_rdata = e_data;
            assign rsp_fault = e_fault;
        end else begin : g_pipe
            logic [RD_LAT-2:0]       pv;
            logic [RD_LAT-2:0]       pf;
            logic [RD_LAT-2:0][31:0] pd;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv <= '0;
                    pf <= '0;
                    pd <= '0;
                end else begin
                    pv[0] <= s1_valid;
                    pf[0] <= e_fault;
                    pd[0] <= e_data;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        pv[i] <= pv[i-1];
                        pf[i] <= pf[i-1];
                        pd[i] <= pd[i-1];
                    end
                end
            end

            assign rsp_valid = pv[RD_LAT-2];
            assign rsp_rdata = pd[RD_LAT-2];
            assign rsp_fault = pf[RD_LAT-2];
        end
    endgenerate

endmodule
